// File: rtl/clk_div_prog.sv
// Programmable clock divider: square-wave or one-cycle pulse output, with a shadowed divisor
// that only takes effect at a period boundary (wrap) or at a sync restart.
module clk_div_prog #(
    parameter int WIDTH       = 20,
    parameter int DEFAULT_DIV = 2**19
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] div_val,
    input  logic             load,
    input  logic             sync,
    input  logic             mode,
    output logic             clk_div,
    output logic             tick,
    output logic             pending,
    output logic             load_err
);

    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);

    logic [WIDTH-1:0] cnt, div_reg, shd;
    logic [WIDTH-1:0] cnt_nxt, div_nxt, shd_nxt;
    logic [WIDTH:0]   half;
    logic             pending_nxt, tick_nxt, clk_div_nxt, load_err_nxt;
    logic             load_ok, wrap, apply;

    always_comb begin
        load_ok      = load && (div_val >= TWO);
        load_err_nxt = load && (div_val < TWO);
        wrap         = en && !sync && (cnt == div_reg - ONE);
        apply        = sync || wrap;

        // A valid load landing on a boundary edge goes straight into div_reg.
        div_nxt = div_reg;
        if (apply) begin
            if (load_ok)
                div_nxt = div_val;
            else if (pending)
                div_nxt = shd;
        end

        shd_nxt = shd;
        if (load_ok && !apply)
            shd_nxt = div_val;

        pending_nxt = pending;
        if (apply)
            pending_nxt = 1'b0;
        else if (load_ok)
            pending_nxt = 1'b1;

        // High threshold is ceil(N/2) of the divisor in force after this edge.
        half = ({1'b0, div_nxt} + {{WIDTH{1'b0}}, 1'b1}) >> 1;

        cnt_nxt     = cnt;
        tick_nxt    = 1'b0;
        clk_div_nxt = clk_div;
        if (sync) begin
            cnt_nxt     = '0;
            clk_div_nxt = !mode;
        end else if (en) begin
            cnt_nxt     = wrap ? '0 : cnt + ONE;
            tick_nxt    = wrap;
            clk_div_nxt = mode ? wrap : ({1'b0, cnt_nxt} < half);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            div_reg  <= DEF_DIV;
            shd      <= DEF_DIV;
            pending  <= 1'b0;
            clk_div  <= 1'b0;
            tick     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            div_reg  <= div_nxt;
            shd      <= shd_nxt;
            pending  <= pending_nxt;
            clk_div  <= clk_div_nxt;
            tick     <= tick_nxt;
            load_err <= load_err_nxt;
        end
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog with hand-computed output sequences.
module tb_clk_div_prog;

    logic       clk, rst, en, load, sync, mode;
    logic [7:0] div_val;
    logic       clk_div, tick, pending, load_err;
    int         checks = 0;
    int         errors = 0;
    logic [15:0] cv, tv;

    clk_div_prog #(.WIDTH(8), .DEFAULT_DIV(4)) dut (
        .clk(clk), .rst(rst), .en(en), .div_val(div_val), .load(load),
        .sync(sync), .mode(mode), .clk_div(clk_div), .tick(tick),
        .pending(pending), .load_err(load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps n edges; first edge ends up in the most significant collected bit.
    task automatic run(input int n, output logic [15:0] c, output logic [15:0] t);
        c = '0;
        t = '0;
        for (int i = 0; i < n; i++) begin
            step();
            c = {c[14:0], clk_div};
            t = {t[14:0], tick};
        end
    endtask

    task automatic pulse_load(input logic [7:0] v);
        load = 1'b1;
        div_val = v;
        step();
        load = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; load = 1'b0; sync = 1'b0; mode = 1'b0; div_val = '0;
        #3;
        check("rst_clk_div", clk_div, 0);
        check("rst_tick", tick, 0);
        check("rst_pending", pending, 0);
        check("rst_load_err", load_err, 0);
        en = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Default divisor 4, square wave
        run(8, cv, tv);
        check("def4_clk", cv, 16'b10011001);
        check("def4_tick", tv, 16'b00010001);
        check("def4_pending", pending, 0);

        // N=5 via pending load, then square and pulse modes
        pulse_load(8'd5);
        check("n5_pending_set", pending, 1);
        run(3, cv, tv);
        check("n5_wrap_tick", tv, 16'b001);
        check("n5_pending_clr", pending, 0);
        run(5, cv, tv);
        check("n5_sq_clk", cv, 16'b11001);
        check("n5_sq_tick", tv, 16'b00001);
        mode = 1'b1;
        run(5, cv, tv);
        check("n5_pulse_clk", cv, 16'b00001);
        check("n5_pulse_tick", tv, 16'b00001);
        mode = 1'b0;

        // N=6 via sync, then load 3 mid-period
        pulse_load(8'd6);
        sync = 1'b1;
        step();
        sync = 1'b0;
        check("sync6_clk", clk_div, 1);
        check("sync6_pending", pending, 0);
        step();
        pulse_load(8'd3);
        check("mid3_pending", pending, 1);
        run(3, cv, tv);
        check("mid3_hold_pending", pending, 1);
        check("mid3_no_tick", tv, 16'b000);
        step();
        check("mid3_wrap_tick", tick, 1);
        check("mid3_wrap_pending", pending, 0);
        run(3, cv, tv);
        check("n3_tick", tv, 16'b001);
        check("n3_clk", cv, 16'b101);

        // Back to 6, then load 3 exactly on the wrap edge
        pulse_load(8'd6);
        run(2, cv, tv);
        check("n6_apply_tick", tv, 16'b01);
        run(5, cv, tv);
        check("n6_no_tick", tv, 16'b00000);
        load = 1'b1;
        div_val = 8'd3;
        step();
        load = 1'b0;
        check("bypass_tick", tick, 1);
        check("bypass_pending", pending, 0);
        run(3, cv, tv);
        check("bypass_n3_tick", tv, 16'b001);
        check("bypass_n3_pending", pending, 0);

        // Rejected loads
        load = 1'b1;
        div_val = 8'd1;
        step();
        check("err1_pulse", load_err, 1);
        check("err1_pending", pending, 0);
        div_val = 8'd0;
        step();
        check("err0_pulse", load_err, 1);
        load = 1'b0;
        step();
        check("err_clear", load_err, 0);
        check("err_wrap_tick", tick, 1);
        run(3, cv, tv);
        check("err_period", tv, 16'b001);
        check("err_pending", pending, 0);

        // N=10, sync while disabled at cnt=7
        load = 1'b1;
        div_val = 8'd10;
        sync = 1'b1;
        step();
        load = 1'b0;
        sync = 1'b0;
        check("n10_pending", pending, 0);
        run(7, cv, tv);
        check("n10_cnt7_clk", clk_div, 0);
        en = 1'b0;
        sync = 1'b1;
        step();
        sync = 1'b0;
        check("sync_en0_clk", clk_div, 1);
        check("sync_en0_tick", tick, 0);
        run(3, cv, tv);
        check("frozen_clk", cv, 16'b111);
        check("frozen_tick", tv, 16'b000);
        en = 1'b1;
        run(9, cv, tv);
        check("resume_clk", cv, 16'b111100000);
        check("resume_tick", tv, 16'b0);
        step();
        check("resume_wrap_tick", tick, 1);
        check("resume_wrap_clk", clk_div, 1);

        // Reset mid-period with a pending divisor
        pulse_load(8'd7);
        run(2, cv, tv);
        check("prerst_pending", pending, 1);
        check("prerst_clk", clk_div, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_clk", clk_div, 0);
        check("async_rst_pending", pending, 0);
        check("async_rst_tick", tick, 0);
        @(negedge clk);
        rst = 1'b0;
        run(4, cv, tv);
        check("postrst_clk", cv, 16'b1001);
        check("postrst_tick", tv, 16'b0001);
        check("postrst_pending", pending, 0);
        run(4, cv, tv);
        check("postrst_period", tv, 16'b0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
